// File: rtl/mmio_pkg.sv
// Shared definitions for the CPU data-side MMIO bridge:
// peripheral window offsets, control bits, region and FSM enums.
package mmio_pkg;

  localparam int WIN_BYTES = 32;

  localparam logic [4:0] OFF_GPIO_OUT = 5'h00;
  localparam logic [4:0] OFF_GPIO_IN  = 5'h04;
  localparam logic [4:0] OFF_T_COUNT  = 5'h08;
  localparam logic [4:0] OFF_T_CMP    = 5'h0C;
  localparam logic [4:0] OFF_T_CTRL   = 5'h10;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_PEND = 1;
  localparam int CTRL_IE   = 2;

  typedef enum logic [1:0] {
    REG_MEM,
    REG_PERIPH,
    REG_ERR
  } region_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/mmio_timer.sv
// Compare timer: free-running count, compare register and control
// with a sticky pending flag and a registered level interrupt.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [2:0]        idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] cmp_o,
  output logic [DATA_W-1:0] ctrl_o,
  output logic              irq_o
);

  localparam int SW = DATA_W / 8;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [SW-1:0]     strb
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic en_q, en_d;
  logic pend_q, pend_d;
  logic ie_q, ie_d;
  logic irq_q;
  logic wr_count, wr_cmp, wr_ctrl, hit;

  assign wr_count = we_i && (idx_i == OFF_T_COUNT[4:2]);
  assign wr_cmp   = we_i && (idx_i == OFF_T_CMP[4:2]);
  assign wr_ctrl  = we_i && (idx_i == OFF_T_CTRL[4:2]);

  // Compare uses the value before this cycle's increment.
  assign hit = en_q && (count_q == cmp_q);

  // Next state: CPU writes beat the increment, a compare hit beats W1C.
  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    if (wr_count) begin
      count_d = merge(count_q, wdata_i, wstrb_i);
    end else if (en_q) begin
      count_d = count_q + DATA_W'(1);
    end
    if (wr_cmp) cmp_d = merge(cmp_q, wdata_i, wstrb_i);
    if (wr_ctrl && wstrb_i[0]) begin
      en_d = wdata_i[CTRL_EN];
      ie_d = wdata_i[CTRL_IE];
      if (wdata_i[CTRL_PEND]) pend_d = 1'b0;
    end
    if (hit) pend_d = 1'b1;
  end

  // Timer state and registered interrupt line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      cmp_q   <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      ie_q    <= ie_d;
      irq_q   <= pend_d & ie_d;
    end
  end

  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign ctrl_o  = {{(DATA_W-3){1'b0}}, ie_q, pend_q, en_q};
  assign irq_o   = irq_q;

endmodule

// File: rtl/mmio_bridge.sv
// Load/store bridge: data RAM pass-through with a read handshake,
// plus a small peripheral window holding GPIO and a compare timer.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                MEM_BYTES   = 2048,
  parameter int                MEM_RD_LAT  = 1,
  parameter logic [ADDR_W-1:0] PERIPH_BASE = 32'h0001_0000,
  parameter int                GPIO_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_re,
  input  logic [ADDR_W-1:0]   cpu_raddr,
  output logic                cpu_busy,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rerr,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_waddr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_werr,
  output logic                ext_re,
  output logic [ADDR_W-1:0]   ext_raddr,
  input  logic [DATA_W-1:0]   ext_rdata,
  output logic                ext_we,
  output logic [ADDR_W-1:0]   ext_waddr,
  output logic [DATA_W-1:0]   ext_wdata,
  output logic [DATA_W/8-1:0] ext_wstrb,
  input  logic [GPIO_W-1:0]   gpio_in,
  output logic [GPIO_W-1:0]   gpio_out,
  output logic                timer_irq
);

  localparam int CNT_W = $clog2(MEM_RD_LAT + 1);

  function automatic region_e decode(input logic [ADDR_W-1:0] a);
    if (a < ADDR_W'(MEM_BYTES)) return REG_MEM;
    if (a >= PERIPH_BASE &&
        a < PERIPH_BASE + ADDR_W'(WIN_BYTES)) return REG_PERIPH;
    return REG_ERR;
  endfunction

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               rvalid_q;
  logic               rerr_q;
  logic               werr_q;
  logic [GPIO_W-1:0]  gpio_q, gpio_d;
  logic [GPIO_W-1:0]  sync1_q, sync2_q;

  region_e            rreg, wreg;
  logic [2:0]         ridx, widx;
  logic               accept, mem_wr, per_wr;
  logic [DATA_W-1:0]  prdata;
  logic [DATA_W-1:0]  t_count, t_cmp, t_ctrl;

  // Window base is 32-byte aligned, so word index is a 3-bit difference.
  assign rreg = decode(cpu_raddr);
  assign wreg = decode(cpu_waddr);
  assign ridx = cpu_raddr[4:2] - PERIPH_BASE[4:2];
  assign widx = cpu_waddr[4:2] - PERIPH_BASE[4:2];

  assign cpu_busy = (state_q != S_IDLE) && (state_q != S_RESP);
  assign accept   = cpu_re && !cpu_busy;

  assign ext_re    = accept && (rreg == REG_MEM);
  assign ext_raddr = ext_re ? cpu_raddr : '0;

  assign mem_wr    = cpu_we && (wreg == REG_MEM);
  assign per_wr    = cpu_we && (wreg == REG_PERIPH);
  assign ext_we    = mem_wr;
  assign ext_waddr = mem_wr ? cpu_waddr : '0;
  assign ext_wdata = mem_wr ? cpu_wdata : '0;
  assign ext_wstrb = mem_wr ? cpu_wstrb : '0;

  // Peripheral read mux; unmapped words read as zero.
  always_comb begin
    prdata = '0;
    unique case (1'b1)
      ridx == OFF_GPIO_OUT[4:2]: prdata = DATA_W'(gpio_q);
      ridx == OFF_GPIO_IN[4:2]:  prdata = DATA_W'(sync2_q);
      ridx == OFF_T_COUNT[4:2]:  prdata = t_count;
      ridx == OFF_T_CMP[4:2]:    prdata = t_cmp;
      ridx == OFF_T_CTRL[4:2]:   prdata = t_ctrl;
      default:                   prdata = '0;
    endcase
  end

  // Byte-strobed update of the GPIO output register.
  always_comb begin
    gpio_d = gpio_q;
    if (per_wr && widx == OFF_GPIO_OUT[4:2]) begin
      for (int i = 0; i < GPIO_W; i++) begin
        if (cpu_wstrb[i/8]) gpio_d[i] = cpu_wdata[i];
      end
    end
  end

  // GPIO output, input synchroniser and write-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      werr_q  <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      werr_q  <= cpu_we && (wreg == REG_ERR);
    end
  end

  // Read FSM; RESP behaves like IDLE so back-to-back reads are possible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      case (state_q)
        S_MEM_WAIT: begin
          if (cnt_q == CNT_W'(MEM_RD_LAT)) begin
            rdata_q  <= ext_rdata;
            rvalid_q <= 1'b1;
            state_q  <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (accept) begin
            unique case (rreg)
              REG_MEM: begin
                cnt_q   <= CNT_W'(1);
                state_q <= S_MEM_WAIT;
              end
              REG_PERIPH: begin
                rdata_q  <= prdata;
                rvalid_q <= 1'b1;
                state_q  <= S_RESP;
              end
              default: begin
                rdata_q  <= '0;
                rerr_q   <= 1'b1;
                rvalid_q <= 1'b1;
                state_q  <= S_RESP;
              end
            endcase
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  mmio_timer #(
    .DATA_W (DATA_W)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (per_wr),
    .idx_i   (widx),
    .wdata_i (cpu_wdata),
    .wstrb_i (cpu_wstrb),
    .count_o (t_count),
    .cmp_o   (t_cmp),
    .ctrl_o  (t_ctrl),
    .irq_o   (timer_irq)
  );

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_rerr   = rerr_q;
  assign cpu_werr   = werr_q;
  assign gpio_out   = gpio_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: one instance with read latency 2
// for most scenarios, one with latency 1 for back-to-back reads.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_raddr, cpu_waddr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [7:0]  gpio_in;

  logic        busy, rvalid, rerr, werr, ere, ewe, irq;
  logic [31:0] rdata, eraddr, erdata, ewaddr, ewdata;
  logic [3:0]  ewstrb;
  logic [7:0]  gpio_out;

  logic        busy1, rvalid1, rerr1, werr1, ere1, ewe1, irq1;
  logic [31:0] rdata1, eraddr1, erdata1, ewaddr1, ewdata1;
  logic [3:0]  ewstrb1;
  logic [7:0]  gpio_out1;

  logic [31:0] p0, p1, q0;

  int nchk = 0;
  int nerr = 0;
  int n_ere = 0, n_ewe = 0, n_werr = 0, n_rv = 0;
  int n_acc1 = 0, n_rv1 = 0, n_ere1 = 0;

  always #5 clk = ~clk;

  mmio_bridge #(.MEM_RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_raddr(cpu_raddr), .cpu_busy(busy),
    .cpu_rvalid(rvalid), .cpu_rdata(rdata), .cpu_rerr(rerr),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_werr(werr),
    .ext_re(ere), .ext_raddr(eraddr), .ext_rdata(erdata),
    .ext_we(ewe), .ext_waddr(ewaddr), .ext_wdata(ewdata),
    .ext_wstrb(ewstrb), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .timer_irq(irq)
  );

  mmio_bridge #(.MEM_RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_raddr(cpu_raddr), .cpu_busy(busy1),
    .cpu_rvalid(rvalid1), .cpu_rdata(rdata1), .cpu_rerr(rerr1),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_werr(werr1),
    .ext_re(ere1), .ext_raddr(eraddr1), .ext_rdata(erdata1),
    .ext_we(ewe1), .ext_waddr(ewaddr1), .ext_wdata(ewdata1),
    .ext_wstrb(ewstrb1), .gpio_in(gpio_in), .gpio_out(gpio_out1),
    .timer_irq(irq1)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return {16'hA5A5, a[15:0]};
  endfunction

  // Memory models: data appears LAT cycles after ext_re.
  always @(posedge clk) begin
    p0 <= ere ? mem_val(eraddr) : 32'h0;
    p1 <= p0;
    q0 <= ere1 ? mem_val(eraddr1) : 32'h0;
  end
  assign erdata  = p1;
  assign erdata1 = q0;

  always @(negedge clk) begin
    if (ere) n_ere++;
    if (ewe) n_ewe++;
    if (werr) n_werr++;
    if (rvalid) n_rv++;
    if (cpu_re && !busy1) n_acc1++;
    if (rvalid1) n_rv1++;
    if (ere1) n_ere1++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    cpu_we    = 1'b1;
    cpu_waddr = a;
    cpu_wdata = d;
    cpu_wstrb = s;
    tick();
    cpu_we    = 1'b0;
    cpu_wstrb = 4'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp_d, input logic exp_e,
                    input int exp_lat);
    int n;
    cpu_re    = 1'b1;
    cpu_raddr = a;
    tick();
    cpu_re = 1'b0;
    n = 1;
    while (!rvalid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_data"}, rdata, exp_d);
    chk({tag, "_err"}, {31'b0, rerr}, {31'b0, exp_e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b0, b1, b2;
    cpu_re = 0; cpu_we = 0;
    cpu_raddr = 0; cpu_waddr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    gpio_in = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_werr", {31'b0, werr}, 32'd0);
    chk("rst_ere", {31'b0, ere}, 32'd0);
    chk("rst_gpio", {24'b0, gpio_out}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    tick();
    rst = 1'b0;

    // memory read, latency 2
    b0 = n_ere;
    cpu_re = 1'b1;
    cpu_raddr = 32'h40;
    @(negedge clk);
    chk("m_ere", {31'b0, ere}, 32'd1);
    chk("m_eraddr", eraddr, 32'h40);
    chk("m_busy0", {31'b0, busy}, 32'd0);
    tick();
    cpu_re = 1'b0;
    @(negedge clk);
    chk("m_busy1", {31'b0, busy}, 32'd1);
    chk("m_rv1", {31'b0, rvalid}, 32'd0);
    tick();
    @(negedge clk);
    chk("m_busy2", {31'b0, busy}, 32'd1);
    chk("m_rv2", {31'b0, rvalid}, 32'd0);
    tick();
    @(negedge clk);
    chk("m_rv3", {31'b0, rvalid}, 32'd1);
    chk("m_rdata", rdata, 32'hDEAD_BEEF);
    chk("m_rerr", {31'b0, rerr}, 32'd0);
    chk("m_busy3", {31'b0, busy}, 32'd0);
    tick();
    chk("m_ere_cnt", 32'(n_ere - b0), 32'd1);
    rd("mem_top", 32'h7FC, 32'hA5A5_07FC, 1'b0, 3);

    // memory write pass-through
    cpu_we = 1'b1;
    cpu_waddr = 32'h100;
    cpu_wdata = 32'h1234_5678;
    cpu_wstrb = 4'b0110;
    @(negedge clk);
    chk("mw_we", {31'b0, ewe}, 32'd1);
    chk("mw_addr", ewaddr, 32'h100);
    chk("mw_data", ewdata, 32'h1234_5678);
    chk("mw_strb", {28'b0, ewstrb}, 32'h6);
    tick();
    cpu_we = 1'b0;

    // GPIO out and strobes
    b0 = n_ewe;
    wr(32'h1_0000, 32'h0000_00A5, 4'b0001);
    chk("gpio_out", {24'b0, gpio_out}, 32'hA5);
    chk("gpio_ewe", 32'(n_ewe - b0), 32'd0);
    rd("gpio_rd", 32'h1_0000, 32'hA5, 1'b0, 1);
    wr(32'h1_0000, 32'hFFFF_FF3C, 4'b1110);
    chk("gpio_strb", {24'b0, gpio_out}, 32'hA5);
    rd("gpio_lsb", 32'h1_0003, 32'hA5, 1'b0, 1);
    gpio_in = 8'h3C;
    tick();
    tick();
    rd("gpio_in", 32'h1_0004, 32'h3C, 1'b0, 1);

    // error accesses
    b0 = n_ere; b1 = n_ewe; b2 = n_werr;
    cpu_re = 1'b1; cpu_raddr = 32'h800;
    cpu_we = 1'b1; cpu_waddr = 32'h2000;
    cpu_wdata = 32'hFFFF_FFFF; cpu_wstrb = 4'hF;
    tick();
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_wstrb = 4'h0;
    chk("e_rv", {31'b0, rvalid}, 32'd1);
    chk("e_rerr", {31'b0, rerr}, 32'd1);
    chk("e_rdata", rdata, 32'd0);
    chk("e_werr", {31'b0, werr}, 32'd1);
    tick();
    chk("e_werr_off", {31'b0, werr}, 32'd0);
    chk("e_ere_cnt", 32'(n_ere - b0), 32'd0);
    chk("e_ewe_cnt", 32'(n_ewe - b1), 32'd0);
    chk("e_werr_cnt", 32'(n_werr - b2), 32'd1);
    rd("win_end", 32'h1_0020, 32'd0, 1'b1, 1);
    rd("unmapped", 32'h1_0014, 32'd0, 1'b0, 1);

    // timer compare, W1C and priorities
    wr(32'h1_000C, 32'd5, 4'hF);
    wr(32'h1_0010, 32'h5, 4'hF);
    repeat (5) tick();
    chk("t_irq_pre", {31'b0, irq}, 32'd0);
    tick();
    chk("t_irq_hit", {31'b0, irq}, 32'd1);
    wr(32'h1_0010, 32'h7, 4'hF);
    chk("t_w1c", {31'b0, irq}, 32'd0);
    wr(32'h1_0008, 32'd3, 4'hF);
    rd("t_count", 32'h1_0008, 32'd3, 1'b0, 1);
    tick();
    cpu_re = 1'b1; cpu_raddr = 32'h1_0010;
    cpu_we = 1'b1; cpu_waddr = 32'h1_0010;
    cpu_wdata = 32'h7; cpu_wstrb = 4'hF;
    tick();
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_wstrb = 4'h0;
    chk("t_hit_w1c", {31'b0, irq}, 32'd1);
    chk("t_old_rd", rdata, 32'h5);
    wr(32'h1_0010, 32'h7, 4'hF);
    chk("t_w1c2", {31'b0, irq}, 32'd0);
    wr(32'h1_0008, 32'hFFFF_FFFF, 4'hF);
    tick();
    rd("t_wrap", 32'h1_0008, 32'd0, 1'b0, 1);
    wr(32'h1_0010, 32'h2, 4'hF);

    // held read request on the latency-1 instance
    tick();
    b0 = n_acc1; b1 = n_rv1; b2 = n_ere1;
    cpu_re = 1'b1;
    cpu_raddr = 32'h10;
    repeat (4) tick();
    cpu_re = 1'b0;
    repeat (4) tick();
    chk("b2b_acc", 32'(n_acc1 - b0), 32'd2);
    chk("b2b_rv", 32'(n_rv1 - b1), 32'd2);
    chk("b2b_ere", 32'(n_ere1 - b2), 32'd2);

    // reset during MEM_WAIT
    cpu_re = 1'b1;
    cpu_raddr = 32'h40;
    tick();
    cpu_re = 1'b0;
    @(negedge clk);
    chk("r_busy_pre", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("r_busy", {31'b0, busy}, 32'd0);
    chk("r_rv", {31'b0, rvalid}, 32'd0);
    chk("r_rdata", rdata, 32'd0);
    chk("r_gpio", {24'b0, gpio_out}, 32'd0);
    chk("r_ere", {31'b0, ere}, 32'd0);
    b0 = n_rv;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("r_no_rv", 32'(n_rv - b0), 32'd0);
    rd("after_rst", 32'h40, 32'hDEAD_BEEF, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
